// File: rtl/alu_pkg.sv
// Shared opcode and iterative-FSM definitions for the multi-cycle ALU.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD    = 4'h0,
      OP_SUB    = 4'h1,
      OP_MUL    = 4'h2,
      OP_DIV    = 4'h3,
      OP_AND    = 4'h4,
      OP_OR     = 4'h5,
      OP_NAND   = 4'h6,
      OP_NOR    = 4'h7,
      OP_XOR    = 4'h8,
      OP_XNOR   = 4'h9,
      OP_CMP_EQ = 4'hA,
      OP_CMP_GT = 4'hB,
      OP_CMP_LT = 4'hC,
      OP_SHR    = 4'hD,
      OP_SHL    = 4'hE,
      OP_RSVD   = 4'hF
   } alu_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ITER = 1'b1
   } iter_state_e;

   // Opcodes handled by the one-bit-per-cycle datapath
   function automatic logic is_iter_op(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
module alu_iter_muldiv
   import alu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      is_div,
   input  logic [DATA_WIDTH-1:0]     a,
   input  logic [DATA_WIDTH-1:0]     b,
   output logic                      busy_c,
   output logic                      done_c,
   output logic                      div_zero,
   output logic [2*DATA_WIDTH-1:0]   result_c
);

   localparam int unsigned W     = DATA_WIDTH;
   localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

   iter_state_e          state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 div_q, div_d;
   logic                 dz_q, dz_d;
   logic [W-1:0]         b_q, b_d;
   logic [2*W-1:0]       acc_q, acc_d;

   logic [W:0]           mul_sum;
   logic [W:0]           div_tmp;
   logic [W-1:0]         div_diff;
   logic                 div_ge;

   assign busy_c   = (state_q == ST_ITER);
   assign div_zero = dz_q;

   // acc holds {hi, lo}: MUL {partial product, multiplier}, DIV {remainder, quotient}
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : '0);
      div_tmp  = {acc_q[2*W-1:W], acc_q[W-1]};
      div_ge   = (div_tmp >= {1'b0, b_q});
      div_diff = div_tmp[W-1:0] - b_q;
      if (div_q) begin
         result_c = {(div_ge ? div_diff : div_tmp[W-1:0]), acc_q[W-2:0], div_ge};
      end else begin
         result_c = {mul_sum, acc_q[W-1:1]};
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      dz_d    = dz_q;
      b_d     = b_q;
      acc_d   = acc_q;
      done_c  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_ITER;
               cnt_d   = CNT_W'(W);
               div_d   = is_div;
               dz_d    = is_div && (b == '0);
               b_d     = b;
               acc_d   = {{W{1'b0}}, a};
            end
         end
         ST_ITER: begin
            acc_d = result_c;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_IDLE;
               done_c  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         div_q   <= 1'b0;
         dz_q    <= 1'b0;
         b_q     <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         dz_q    <= dz_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
      end
   end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle ops computed here, MUL/DIV delegated to the iterative unit.
module alu_multicycle
   import alu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [DATA_WIDTH-1:0]     A,
   input  logic [DATA_WIDTH-1:0]     B,
   input  logic [3:0]                ALU_FUNC,
   input  logic                      ALU_EN,
   output logic [2*DATA_WIDTH-1:0]   ALU_OUT,
   output logic                      ALU_vld_OUT,
   output logic                      ALU_ERR,
   output logic                      BUSY
);

   localparam int unsigned W = DATA_WIDTH;

   logic             accept_c;
   logic             iter_c;
   logic             done_c;
   logic             div_zero;
   logic             busy_c;
   logic [2*W-1:0]   iter_res_c;
   logic [W:0]       sum_c;
   logic [W:0]       diff_c;
   logic [W-1:0]     narrow_c;
   logic [2*W-1:0]   sc_res_c;
   logic             sc_err_c;

   assign accept_c = ALU_EN && !busy_c;
   assign iter_c   = is_iter_op(ALU_FUNC);
   assign BUSY     = busy_c;

   alu_iter_muldiv #(.DATA_WIDTH(W)) u_iter (
      .clk      (CLK),
      .rst_n    (RST),
      .start    (accept_c && iter_c),
      .is_div   (ALU_FUNC == OP_DIV),
      .a        (A),
      .b        (B),
      .busy_c   (busy_c),
      .done_c   (done_c),
      .div_zero (div_zero),
      .result_c (iter_res_c)
   );

   // Single-cycle result; bit W of the difference is the borrow
   always_comb begin
      sum_c    = {1'b0, A} + {1'b0, B};
      diff_c   = {1'b0, A} - {1'b0, B};
      narrow_c = '0;
      sc_err_c = 1'b0;
      case (alu_op_e'(ALU_FUNC))
         OP_AND:    narrow_c = A & B;
         OP_OR:     narrow_c = A | B;
         OP_NAND:   narrow_c = ~(A & B);
         OP_NOR:    narrow_c = ~(A | B);
         OP_XOR:    narrow_c = A ^ B;
         OP_XNOR:   narrow_c = ~(A ^ B);
         OP_CMP_EQ: narrow_c = (A == B) ? W'(1) : '0;
         OP_CMP_GT: narrow_c = (A > B)  ? W'(2) : '0;
         OP_CMP_LT: narrow_c = (A < B)  ? W'(3) : '0;
         OP_SHR:    narrow_c = {1'b0, A[W-1:1]};
         OP_SHL:    narrow_c = {A[W-2:0], 1'b0};
         OP_RSVD:   sc_err_c = 1'b1;
         default:   narrow_c = '0;
      endcase
      case (alu_op_e'(ALU_FUNC))
         OP_ADD:  sc_res_c = {{(W-1){1'b0}}, sum_c};
         OP_SUB:  sc_res_c = {{(W-1){1'b0}}, diff_c};
         default: sc_res_c = {{W{1'b0}}, narrow_c};
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         ALU_OUT     <= '0;
         ALU_vld_OUT <= 1'b0;
         ALU_ERR     <= 1'b0;
      end else begin
         ALU_vld_OUT <= 1'b0;
         if (done_c) begin
            ALU_OUT     <= iter_res_c;
            ALU_vld_OUT <= 1'b1;
            ALU_ERR     <= div_zero;
         end else if (accept_c && !iter_c) begin
            ALU_OUT     <= sc_res_c;
            ALU_vld_OUT <= 1'b1;
            ALU_ERR     <= sc_err_c;
         end
      end
   end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle (W=8 main instance, W=16 multiply sweep).
module tb_alu_multicycle;
   import alu_pkg::*;

   localparam int unsigned W = 8;

   logic          CLK;
   logic          RST;
   logic [W-1:0]  a, b;
   logic [3:0]    func;
   logic          en;
   logic [2*W-1:0] out;
   logic          vld, err, busy;

   logic [15:0]   a16, b16;
   logic [3:0]    func16;
   logic          en16;
   logic [31:0]   out16;
   logic          vld16, err16, busy16;

   int n_checks = 0;
   int n_fail   = 0;

   alu_multicycle #(.DATA_WIDTH(W)) u_dut (
      .CLK(CLK), .RST(RST), .A(a), .B(b), .ALU_FUNC(func), .ALU_EN(en),
      .ALU_OUT(out), .ALU_vld_OUT(vld), .ALU_ERR(err), .BUSY(busy)
   );

   alu_multicycle #(.DATA_WIDTH(16)) u_dut16 (
      .CLK(CLK), .RST(RST), .A(a16), .B(b16), .ALU_FUNC(func16), .ALU_EN(en16),
      .ALU_OUT(out16), .ALU_vld_OUT(vld16), .ALU_ERR(err16), .BUSY(busy16)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present a request for exactly one rising edge; returns 1ns after that edge
   task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
      @(negedge CLK);
      func = op;
      a    = x;
      b    = y;
      en   = 1'b1;
      @(posedge CLK);
      #1;
      en = 1'b0;
   endtask

   task automatic wait_vld(output int edges, output int busy_cnt);
      edges    = 0;
      busy_cnt = busy ? 1 : 0;
      while (!vld && edges < 40) begin
         @(posedge CLK);
         #1;
         edges++;
         if (!vld && busy) busy_cnt++;
      end
   endtask

   task automatic run_sc(input string tag, input logic [3:0] op, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [2*W-1:0] exp, input logic e);
      issue(op, x, y);
      check({tag, " out"},  64'(out),  64'(exp));
      check({tag, " vld"},  64'(vld),  64'd1);
      check({tag, " err"},  64'(err),  64'(e));
      check({tag, " busy"}, 64'(busy), 64'd0);
   endtask

   initial begin
      int edges, bcnt, nv;
      RST = 1'b1; en = 1'b0; a = '0; b = '0; func = '0;
      en16 = 1'b0; a16 = '0; b16 = '0; func16 = '0;
      #2 RST = 1'b0;
      #2;
      check("rst out",   64'(out),   64'd0);
      check("rst vld",   64'(vld),   64'd0);
      check("rst err",   64'(err),   64'd0);
      check("rst busy",  64'(busy),  64'd0);
      check("rst out16", 64'(out16), 64'd0);
      repeat (2) @(negedge CLK);
      RST = 1'b1;

      run_sc("add_carry", OP_ADD, 8'hFF, 8'h01, 16'h0100, 1'b0);
      @(posedge CLK); #1;
      check("add vld_pulse", 64'(vld), 64'd0);
      check("add hold",      64'(out), 64'h0100);

      // Operands are scrambled mid-flight; the latched ones must win
      issue(OP_MUL, 8'hFF, 8'hFF);
      a = 8'h00; b = 8'h00; func = OP_DIV;
      check("mul busy_start", 64'(busy), 64'd1);
      wait_vld(edges, bcnt);
      check("mul latency",  64'(edges), 64'd8);
      check("mul busy_cyc", 64'(bcnt),  64'd8);
      check("mul out",      64'(out),   64'hFE01);
      check("mul err",      64'(err),   64'd0);
      check("mul busy_vld", 64'(busy),  64'd0);
      @(posedge CLK); #1;
      check("mul vld_pulse", 64'(vld), 64'd0);

      issue(OP_DIV, 8'd200, 8'd7);
      wait_vld(edges, bcnt);
      check("div latency", 64'(edges), 64'd8);
      check("div out",     64'(out),   64'h041C);
      check("div err",     64'(err),   64'd0);

      issue(OP_DIV, 8'h55, 8'h00);
      wait_vld(edges, bcnt);
      check("div0 latency", 64'(edges), 64'd8);
      check("div0 out",     64'(out),   64'h55FF);
      check("div0 err",     64'(err),   64'd1);

      // ADD presented on edge 3 of a MUL must be dropped
      issue(OP_MUL, 8'h12, 8'h34);
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      func = OP_ADD; a = 8'h01; b = 8'h01; en = 1'b1;
      @(posedge CLK); #1;
      en = 1'b0;
      wait_vld(edges, bcnt);
      check("mul_ign latency", 64'(edges), 64'd5);
      check("mul_ign out",     64'(out),   64'h03A8);
      check("mul_ign err",     64'(err),   64'd0);
      func = OP_CMP_GT; a = 8'd9; b = 8'd3; en = 1'b1;
      @(posedge CLK); #1;
      en = 1'b0;
      check("b2b_gt out", 64'(out), 64'h0002);
      check("b2b_gt vld", 64'(vld), 64'd1);

      issue(OP_DIV, 8'd200, 8'd7);
      repeat (2) @(posedge CLK);
      #3 RST = 1'b0;
      #1;
      check("rst_mid out",  64'(out),  64'd0);
      check("rst_mid vld",  64'(vld),  64'd0);
      check("rst_mid err",  64'(err),  64'd0);
      check("rst_mid busy", 64'(busy), 64'd0);
      @(negedge CLK);
      RST = 1'b1;
      nv = 0;
      repeat (12) begin
         @(posedge CLK); #1;
         if (vld) nv++;
      end
      check("rst_mid no_vld", 64'(nv), 64'd0);
      run_sc("sub_borrow", OP_SUB, 8'h03, 8'h05, 16'h01FE, 1'b0);

      run_sc("rsvd", 4'hF, 8'h05, 8'h06, 16'h0000, 1'b1);
      @(posedge CLK); #1;
      check("rsvd vld_pulse", 64'(vld), 64'd0);
      check("rsvd err_hold",  64'(err), 64'd1);

      run_sc("and",    OP_AND,    8'hF0, 8'h3C, 16'h0030, 1'b0);
      run_sc("or",     OP_OR,     8'hF0, 8'h3C, 16'h00FC, 1'b0);
      run_sc("nand",   OP_NAND,   8'hF0, 8'h3C, 16'h00CF, 1'b0);
      run_sc("nor",    OP_NOR,    8'hF0, 8'h3C, 16'h0003, 1'b0);
      run_sc("xor",    OP_XOR,    8'hF0, 8'h3C, 16'h00CC, 1'b0);
      run_sc("xnor",   OP_XNOR,   8'hF0, 8'h3C, 16'h0033, 1'b0);
      run_sc("eq_t",   OP_CMP_EQ, 8'h05, 8'h05, 16'h0001, 1'b0);
      run_sc("eq_f",   OP_CMP_EQ, 8'h05, 8'h06, 16'h0000, 1'b0);
      run_sc("gt_f",   OP_CMP_GT, 8'h03, 8'h09, 16'h0000, 1'b0);
      run_sc("lt_t",   OP_CMP_LT, 8'h03, 8'h09, 16'h0003, 1'b0);
      run_sc("shr",    OP_SHR,    8'h81, 8'h00, 16'h0040, 1'b0);
      run_sc("shl",    OP_SHL,    8'h81, 8'h00, 16'h0002, 1'b0);
      run_sc("sub",    OP_SUB,    8'h05, 8'h03, 16'h0002, 1'b0);

      @(negedge CLK);
      func16 = OP_MUL; a16 = 16'hFFFF; b16 = 16'hFFFF; en16 = 1'b1;
      @(posedge CLK); #1;
      en16 = 1'b0;
      edges = 0;
      while (!vld16 && edges < 60) begin
         @(posedge CLK); #1;
         edges++;
      end
      check("mul16 latency", 64'(edges), 64'd16);
      check("mul16 out",     64'(out16), 64'hFFFE0001);
      check("mul16 err",     64'(err16), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
